// File: rtl/green_seq.sv
// Instruction sequencer for the green block: fetches over an imem req/ack handshake,
// runs FETCH/DECODE/EXEC/WB per instruction, and handles halt and fetch timeout.
module green_seq #(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
  parameter int unsigned   TMO      = 15,
  parameter logic [3:0]    HALT_OP  = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   ins_o,
  input  logic          g_br,
  input  logic          g_we,
  input  logic [15:0]   g_ra,
  output logic          rf_we,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Last no-ack cycle count before the fetch is abandoned.
  localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);
  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ins_q, ins_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          br_q, br_d;
  logic [AW-1:0] ra_q, ra_d;
  logic          req_q, req_d;
  logic          rf_we_q, rf_we_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    tmo_d    = tmo_q;
    br_d     = br_q;
    ra_d     = ra_q;
    rf_we_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        // An ack on the final allowed cycle still completes the fetch.
        if (imem_ack) begin
          ins_d   = imem_rdata;
          tmo_d   = 8'd0;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = tmo_q + 8'd1;
          state_d = S_ERR;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (ins_q[15:12] == HALT_OP) state_d = S_HALT;
        else                         state_d = S_EXEC;
      end
      S_EXEC: begin
        br_d    = g_br;
        ra_d    = g_ra[AW-1:0];
        rf_we_d = g_we;
        state_d = S_WB;
      end
      S_WB: begin
        if (br_q) pc_d = ra_q;
        else      pc_d = pc_q + PC_ONE;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_ERR: begin
        if (start) begin
          tmo_d   = 8'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d    = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_ERR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ins_q    <= 16'h0000;
      tmo_q    <= 8'd0;
      br_q     <= 1'b0;
      ra_q     <= {AW{1'b0}};
      req_q    <= 1'b0;
      rf_we_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      tmo_q    <= tmo_d;
      br_q     <= br_d;
      ra_q     <= ra_d;
      req_q    <= req_d;
      rf_we_q  <= rf_we_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins_o     = ins_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_green_seq.sv
// Self-checking bench for green_seq: directed vector table, hand-written corner
// sequences (timeout, mid-instruction reset) and randomized instruction stream.
module tb_green_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ins_o;
  logic        g_br;
  logic        g_we;
  logic [15:0] g_ra;
  logic        rf_we;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [15:0] mpc;

  green_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ins_o(ins_o),
    .g_br(g_br), .g_we(g_we), .g_ra(g_ra),
    .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    int          waits;
    logic        br;
    logic        we;
    logic [15:0] ra;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc model %h)", nm, act, expv, mpc);
    end
  endtask

  // Entry and exit: at a negedge with the sequencer in FETCH at address mpc.
  task automatic instr(input logic [15:0] rdata, input int waits, input logic br,
                       input logic we, input logic [15:0] ra, input logic [15:0] exp_next);
    for (int w = 0; w < waits; w++) begin
      chk("fetch_wait_req", {15'd0, imem_req}, 16'd1);
      chk("fetch_wait_addr", imem_addr, mpc);
      @(negedge clk);
    end
    chk("fetch_req", {15'd0, imem_req}, 16'd1);
    chk("fetch_addr", imem_addr, mpc);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    chk("decode_ins", ins_o, rdata);
    chk("decode_busy", {15'd0, busy}, 16'd1);
    chk("decode_rfwe", {15'd0, rf_we}, 16'd0);
    if (rdata[15:12] == 4'hF) begin
      start = 1'b0;
      @(negedge clk);
      chk("halt_halted", {15'd0, halted}, 16'd1);
      chk("halt_busy", {15'd0, busy}, 16'd0);
      chk("halt_rfwe", {15'd0, rf_we}, 16'd0);
      chk("halt_req", {15'd0, imem_req}, 16'd0);
      chk("halt_pc", pc, mpc);
      imem_ack = 1'b1;
      imem_rdata = ~rdata;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("halt_ins_hold", ins_o, rdata);
      chk("halt_still", {15'd0, halted}, 16'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("resume_halted", {15'd0, halted}, 16'd0);
      chk("resume_addr", imem_addr, exp_next);
    end else begin
      g_br = br;
      g_we = we;
      g_ra = ra;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exec_rfwe", {15'd0, rf_we}, 16'd0);
      chk("exec_busy", {15'd0, busy}, 16'd1);
      @(negedge clk);
      chk("wb_rfwe", {15'd0, rf_we}, {15'd0, we});
      chk("wb_pc", pc, mpc);
      g_br = 1'($urandom);
      g_we = 1'($urandom);
      g_ra = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
      chk("next_rfwe", {15'd0, rf_we}, 16'd0);
      chk("next_req", {15'd0, imem_req}, 16'd1);
      chk("next_addr", imem_addr, exp_next);
    end
    mpc = exp_next;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h1000, 0,  1'b0, 1'b1, 16'h0000, 16'h0001};
    vecs[1]  = '{16'h1000, 0,  1'b0, 1'b1, 16'h0000, 16'h0002};
    vecs[2]  = '{16'h1000, 0,  1'b0, 1'b1, 16'h0000, 16'h0003};
    vecs[3]  = '{16'h2345, 3,  1'b0, 1'b0, 16'h0099, 16'h0004};
    vecs[4]  = '{16'h3000, 0,  1'b0, 1'b1, 16'h0000, 16'h0005};
    vecs[5]  = '{16'h4000, 1,  1'b1, 1'b0, 16'h0040, 16'h0040};
    vecs[6]  = '{16'h5000, 14, 1'b1, 1'b1, 16'h0007, 16'h0007};
    vecs[7]  = '{16'hF000, 0,  1'b0, 1'b1, 16'h0000, 16'h0008};
    vecs[8]  = '{16'h6000, 0,  1'b1, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[9]  = '{16'h7000, 0,  1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[10] = '{16'h8000, 0,  1'b1, 1'b1, 16'h1234, 16'h1234};

    rst_n = 1'b0;
    start = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    g_br = 1'b0;
    g_we = 1'b0;
    g_ra = 16'h0000;
    mpc = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ins", ins_o, 16'h0000);
    chk("rst_flags", {11'd0, imem_req, rf_we, busy, halted, err}, 16'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      instr(vecs[i].rdata, vecs[i].waits, vecs[i].br, vecs[i].we, vecs[i].ra, vecs[i].exp_next);
    end

    // Fetch timeout: 15 request cycles with no ack, then ERR.
    for (int k = 0; k < 15; k++) begin
      chk("tmo_req", {15'd0, imem_req}, 16'd1);
      chk("tmo_err_low", {15'd0, err}, 16'd0);
      @(negedge clk);
    end
    chk("tmo_err", {15'd0, err}, 16'd1);
    chk("tmo_req_drop", {15'd0, imem_req}, 16'd0);
    chk("tmo_busy", {15'd0, busy}, 16'd0);
    chk("tmo_pc", pc, mpc);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("err_ack_ignored", {15'd0, err}, 16'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("retry_err", {15'd0, err}, 16'd0);
    instr(16'h9000, 14, 1'b0, 1'b1, 16'h0000, mpc + 16'd1);

    // Reset asserted during EXEC with g_we=1.
    imem_ack = 1'b1;
    imem_rdata = 16'h2222;
    @(negedge clk);
    imem_ack = 1'b0;
    g_we = 1'b1;
    g_br = 1'b1;
    g_ra = 16'h00AA;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_ins", ins_o, 16'h0000);
    chk("arst_flags", {11'd0, imem_req, rf_we, busy, halted, err}, 16'd0);
    @(negedge clk);
    chk("arst_hold_rfwe", {15'd0, rf_we}, 16'd0);
    rst_n = 1'b1;
    g_we = 1'b0;
    g_br = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {11'd0, imem_req, rf_we, busy, halted, err}, 16'd0);
    chk("post_rst_pc", pc, 16'h0000);

    // Randomized instruction stream against the arithmetic PC model.
    mpc = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] rd;
      logic        br;
      logic        we;
      logic [15:0] ra;
      logic [15:0] nxt;
      rd = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rd[15:12] = 4'hF;
      else if (rd[15:12] == 4'hF)    rd[15:12] = 4'hE;
      br = ($urandom_range(0, 3) == 0);
      we = 1'($urandom);
      ra = 16'($urandom);
      if (rd[15:12] == 4'hF) nxt = mpc + 16'd1;
      else if (br)           nxt = ra;
      else                   nxt = mpc + 16'd1;
      instr(rd, $urandom_range(0, 14), br, we, ra, nxt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
